// File: rtl/demux_1_8_hs.sv
// 1-to-8 demultiplexer with valid/ready handshakes: one producer, eight independently drained holding registers.
// Optional transfer counter (xfer_cnt) is built when DEMUX_XFER_CNT_EN is defined.
module demux_1_8_hs #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   s,
    input  logic [W-1:0] d,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] y0,
    output logic [W-1:0] y1,
    output logic [W-1:0] y2,
    output logic [W-1:0] y3,
    output logic [W-1:0] y4,
    output logic [W-1:0] y5,
    output logic [W-1:0] y6,
    output logic [W-1:0] y7,
    output logic [7:0]   out_valid,
    input  logic [7:0]   out_ready
`ifdef DEMUX_XFER_CNT_EN
    ,
    output logic [7:0]   xfer_cnt
`endif
);

    logic [7:0]     w_sel;
    logic [7:0]     w_valid;
    logic [7:0]     w_load;
    logic [8*W-1:0] w_y_flat;
    logic           w_in_ready;
    logic           w_accept;

    always_comb begin
        w_sel = 8'h00;
        case (s)
            3'd0: w_sel = 8'h01;
            3'd1: w_sel = 8'h02;
            3'd2: w_sel = 8'h04;
            3'd3: w_sel = 8'h08;
            3'd4: w_sel = 8'h10;
            3'd5: w_sel = 8'h20;
            3'd6: w_sel = 8'h40;
            3'd7: w_sel = 8'h80;
        endcase
    end

    // Only the addressed channel can stall the producer; a draining channel frees its slot this cycle.
    assign w_in_ready = !w_valid[s] || out_ready[s];
    assign w_accept   = in_valid && w_in_ready;
    assign w_load     = w_accept ? w_sel : 8'h00;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ch
            logic [W-1:0] r_y;
            logic         r_valid;

            // A load in the same cycle as a drain keeps the channel full with the new word.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_y     <= '0;
                    r_valid <= 1'b0;
                end else if (w_load[gi]) begin
                    r_y     <= d;
                    r_valid <= 1'b1;
                end else if (r_valid && out_ready[gi]) begin
                    r_valid <= 1'b0;
                end
            end

            assign w_valid[gi]              = r_valid;
            assign w_y_flat[gi*W +: W]      = r_y;
        end
    endgenerate

    assign in_ready  = w_in_ready;
    assign out_valid = w_valid;
    assign y0 = w_y_flat[0*W +: W];
    assign y1 = w_y_flat[1*W +: W];
    assign y2 = w_y_flat[2*W +: W];
    assign y3 = w_y_flat[3*W +: W];
    assign y4 = w_y_flat[4*W +: W];
    assign y5 = w_y_flat[5*W +: W];
    assign y6 = w_y_flat[6*W +: W];
    assign y7 = w_y_flat[7*W +: W];

`ifdef DEMUX_XFER_CNT_EN
    logic [7:0] r_xfer_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt <= 8'd0;
        end else if (w_accept) begin
            r_xfer_cnt <= r_xfer_cnt + 8'd1;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

endmodule
